// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared state encoding and counter constants for the PWM capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_capture_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int CNT_W_DEF = 16;

   // Counter saturation value at the default width; reaching it means no edge arrived in time.
   localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// sync_edge: 2-flop synchroniser for pwm_in, optional 3-sample glitch filter (PWM_CAPTURE_FILTER_EN),
// single-cycle rise/fall pulses. Latency: pin to edge pulse 2 clk, 4 clk with the filter.
// Backpressure: none; edges are produced every cycle they occur.
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_in,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic lvl_q;

`ifdef PWM_CAPTURE_FILTER_EN
   logic h1;
   logic h2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         h1    <= 1'b0;
         h2    <= 1'b0;
         lvl_q <= 1'b0;
      end else begin
         s1    <= pwm_in;
         s2    <= s1;
         h1    <= s2;
         h2    <= h1;
         lvl_q <= lvl;
      end
   end

   // Level follows the synchroniser only once three consecutive samples agree.
   always_comb begin
      lvl = lvl_q;
      if ((s2 == h1) && (h1 == h2)) begin
         lvl = s2;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         lvl_q <= 1'b0;
      end else begin
         s1    <= pwm_in;
         s2    <= s1;
         lvl_q <= lvl;
      end
   end

   assign lvl = s2;
`endif

   assign rise = lvl & ~lvl_q;
   assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures rise-to-rise period and high time of an asynchronous PWM input (filter: PWM_CAPTURE_FILTER_EN).
// Latency: pwm_in rise to meas_valid 3 clk, 5 clk with the filter.
// Backpressure: none; period/high are overwritten each period, meas_valid is a one-cycle pulse.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   input  logic             clr,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high,
   output logic             meas_valid,
   output logic             ovf,
   output logic             stuck_lvl
);

   localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic lvl;
   logic rise;
   logic fall;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] high_tmp;
   logic [CNT_W-1:0] high_tmp_nx;
   logic [CNT_W-1:0] period_nx;
   logic [CNT_W-1:0] high_nx;
   logic             meas_valid_nx;
   logic             ovf_nx;
   logic             stuck_lvl_nx;

   sync_edge u_sync_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .lvl    (lvl),
      .rise   (rise),
      .fall   (fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         high_tmp   <= '0;
         period     <= '0;
         high       <= '0;
         meas_valid <= 1'b0;
         ovf        <= 1'b0;
         stuck_lvl  <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         high_tmp   <= high_tmp_nx;
         period     <= period_nx;
         high       <= high_nx;
         meas_valid <= meas_valid_nx;
         ovf        <= ovf_nx;
         stuck_lvl  <= stuck_lvl_nx;
      end
   end

   // cnt counts from the last accepted rise; saturation beats any edge in the same cycle.
   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      high_tmp_nx   = high_tmp;
      period_nx     = period;
      high_nx       = high;
      meas_valid_nx = 1'b0;
      ovf_nx        = ovf;
      stuck_lvl_nx  = stuck_lvl;

      if (clr) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         ovf_nx   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state_nx = HIGH;
                  cnt_nx   = CNT_ONE;
               end
            end
            HIGH: begin
               if (cnt == CNT_TOP) begin
                  state_nx     = IDLE;
                  cnt_nx       = '0;
                  ovf_nx       = 1'b1;
                  stuck_lvl_nx = lvl;
               end else if (fall) begin
                  state_nx    = LOW;
                  high_tmp_nx = cnt;
                  cnt_nx      = cnt + CNT_ONE;
               end else begin
                  cnt_nx = cnt + CNT_ONE;
               end
            end
            LOW: begin
               if (cnt == CNT_TOP) begin
                  state_nx     = IDLE;
                  cnt_nx       = '0;
                  ovf_nx       = 1'b1;
                  stuck_lvl_nx = lvl;
               end else if (rise) begin
                  state_nx      = HIGH;
                  period_nx     = cnt;
                  high_nx       = high_tmp;
                  meas_valid_nx = 1'b1;
                  cnt_nx        = CNT_ONE;
               end else begin
                  cnt_nx = cnt + CNT_ONE;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

endmodule
